// File: rtl/display_pkg.sv
// Shared constants for the seven-segment display path: hex segment codes
// ({g,f,e,d,c,b,a}, active low) and pin polarities.
package display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic AN_ON   = 1'b0;
    localparam logic AN_OFF  = 1'b1;
    localparam logic DP_ON   = 1'b0;
    localparam logic DP_OFF  = 1'b1;

    localparam logic [6:0] SEG_CODE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/hex_display_scan_if.sv
// Datapath-side bus of the display driver: value, display options and the
// load strobe that captures them.
interface hex_display_scan_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic                load;
    logic                blank_lz;
    logic [DIGITS-1:0]   blink_mask;
    logic [DIGITS-1:0]   dp_mask;

    modport master (output value, load, blank_lz, blink_mask, dp_mask);
    modport slave  (input  value, load, blank_lz, blink_mask, dp_mask);
endinterface

// File: rtl/hex_seg_lut.sv
// Combinational hex nibble to active-low seven-segment decode.
module hex_seg_lut
    import display_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);
    assign seg_o = SEG_CODE[nib_i];
endmodule

// File: rtl/hex_display_scan.sv
// Multiplexed common-anode hex display driver with frame-synchronous update,
// leading-zero blanking, per-digit blink/dp and an anode guard cycle.
module hex_display_scan
    import display_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    hex_display_scan_if.slave bus,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an,
    output logic              dp,
    output logic              frame_start
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

    typedef struct packed {
        logic [4*DIGITS-1:0] value;
        logic                blank_lz;
        logic [DIGITS-1:0]   blink_mask;
        logic [DIGITS-1:0]   dp_mask;
    } cfg_t;

    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [BLK_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic              blink_on_q, blink_on_d;
    cfg_t              pend_q, pend_d, shad_q, shad_d, cfg_in;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic              dp_q, dp_d;
    logic              fs_q, fs_d;

    logic              dwell_end, frame_bnd;
    logic [3:0]        nib;
    logic [6:0]        lut_seg;
    logic [DIGITS-1:0] lz_blank;
    logic              all_zero;
    logic              sel_lz, sel_blink, sel_dp, blink_off;

    assign cfg_in = '{value:      bus.value,
                      blank_lz:   bus.blank_lz,
                      blink_mask: bus.blink_mask,
                      dp_mask:    bus.dp_mask};

    always_comb begin
        dwell_end   = (div_cnt_q == DIV_LAST);
        frame_bnd   = dwell_end && (idx_q == IDX_LAST);
        div_cnt_d   = dwell_end ? '0 : div_cnt_q + DIV_W'(1);
        idx_d       = idx_q;
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        if (dwell_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
        if (frame_bnd) begin
            if (blink_cnt_q == BLK_LAST) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLK_W'(1);
            end
        end
        // A load on the boundary cycle lands in shadow directly via pend_d.
        pend_d = bus.load ? cfg_in : pend_q;
        shad_d = frame_bnd ? pend_d : shad_q;
    end

    always_comb begin
        lz_blank = '0;
        all_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            all_zero    = all_zero & (shad_q.value[4*i +: 4] == 4'h0);
            lz_blank[i] = shad_q.blank_lz & all_zero & (i != 0);
        end
    end

    always_comb begin
        nib       = 4'h0;
        sel_lz    = 1'b0;
        sel_blink = 1'b0;
        sel_dp    = 1'b0;
        an_d      = {DIGITS{AN_OFF}};
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib       = shad_q.value[4*i +: 4];
                sel_lz    = lz_blank[i];
                sel_blink = shad_q.blink_mask[i];
                sel_dp    = shad_q.dp_mask[i];
                // First dwell cycle keeps every anode off while seg settles.
                if (div_cnt_q != '0) an_d[i] = AN_ON;
            end
        end
    end

    hex_seg_lut u_lut (
        .nib_i (nib),
        .seg_o (lut_seg)
    );

    always_comb begin
        blink_off = sel_blink & ~blink_on_q;
        seg_d     = (sel_lz | blink_off) ? SEG_BLANK : lut_seg;
        dp_d      = (sel_dp && !blink_off && (div_cnt_q != '0)) ? DP_ON : DP_OFF;
        fs_d      = (div_cnt_q == '0) && (idx_q == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q   <= '0;
            idx_q       <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            pend_q      <= '0;
            shad_q      <= '0;
            seg_q       <= SEG_BLANK;
            an_q        <= {DIGITS{AN_OFF}};
            dp_q        <= DP_OFF;
            fs_q        <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            pend_q      <= pend_d;
            shad_q      <= shad_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            dp_q        <= dp_d;
            fs_q        <= fs_d;
        end
    end

    assign seg         = seg_q;
    assign an          = an_q;
    assign dp          = dp_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_hex_display_scan.sv
// Directed bench for hex_display_scan with DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2.
module tb_hex_display_scan;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] SB = 7'b1111111;

    // Expected lit-cycle segments packed {digit3, digit2, digit1, digit0}.
    localparam logic [27:0] P_ZERO = {S0, S0, S0, S0};
    localparam logic [27:0] P_A3F0 = {7'b0001000, 7'b0110000, 7'b0001110, S0};
    localparam logic [27:0] P_LZ40 = {SB, SB, 7'b0011001, S0};
    localparam logic [27:0] P_LZ0  = {SB, SB, SB, S0};
    localparam logic [27:0] P_BLNK = {S0, S0, SB, S0};
    localparam logic [27:0] P_5678 = {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000};

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       frame_start;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    hex_display_scan_if #(.DIGITS(4)) bus ();

    hex_display_scan #(
        .DIGITS       (4),
        .SCAN_DIV     (4),
        .BLINK_FRAMES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .seg         (seg),
        .an          (an),
        .dp          (dp),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        assert (act === exp) n_pass++;
        else $error("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, act, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_seg"}, 32'(seg), 32'h7F);
        check({tag, "_an"},  32'(an),  32'hF);
        check({tag, "_dp"},  32'(dp),  32'h1);
        check({tag, "_fs"},  32'(frame_start), 32'h0);
    endtask

    // One clock; check the output for scan position cyc against the expected pattern.
    task automatic step(input logic [27:0] segs, input logic [3:0] dps);
        int         ph, d;
        logic [3:0] exp_an;
        logic       exp_dp;
        @(posedge clk);
        #1;
        ph = cyc % 4;
        d  = (cyc / 4) % 4;
        exp_an = (ph == 0) ? 4'hF : ~(4'b0001 << d);
        check("an", 32'(an), 32'(exp_an));
        check("frame_start", 32'(frame_start), 32'(cyc % 16 == 0));
        if (ph == 0) begin
            check("dp_guard", 32'(dp), 32'h1);
        end else begin
            exp_dp = dps[d] ? 1'b0 : 1'b1;
            check("seg", 32'(seg), 32'(segs[7*d +: 7]));
            check("dp", 32'(dp), 32'(exp_dp));
        end
        cyc++;
    endtask

    task automatic run(input int n, input logic [27:0] segs, input logic [3:0] dps);
        repeat (n) step(segs, dps);
    endtask

    task automatic drive(input logic [15:0] v, input logic lz, input logic [3:0] bm,
                         input logic [3:0] dm);
        bus.value      = v;
        bus.blank_lz   = lz;
        bus.blink_mask = bm;
        bus.dp_mask    = dm;
        bus.load       = 1'b1;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.value      = '0;
        bus.load       = 1'b0;
        bus.blank_lz   = 1'b0;
        bus.blink_mask = '0;
        bus.dp_mask    = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;

        // Frames 0-1: idle scan of "0000".
        run(32, P_ZERO, 4'b0000);

        // Frame 2: mid-frame load of A3F0; frame 3 shows it.
        run(5, P_ZERO, 4'b0000);
        drive(16'hA3F0, 1'b0, 4'b0000, 4'b0000);
        run(1, P_ZERO, 4'b0000);
        bus.load  = 1'b0;
        bus.value = 16'h0000;
        run(10, P_ZERO, 4'b0000);
        run(16, P_A3F0, 4'b0000);

        // Frames 4-7: leading-zero blanking of 0040, then of 0000.
        run(3, P_A3F0, 4'b0000);
        drive(16'h0040, 1'b1, 4'b0000, 4'b0000);
        run(1, P_A3F0, 4'b0000);
        bus.load = 1'b0;
        run(12, P_A3F0, 4'b0000);
        run(16, P_LZ40, 4'b0000);
        run(7, P_LZ40, 4'b0000);
        drive(16'h0000, 1'b1, 4'b0000, 4'b0000);
        run(1, P_LZ40, 4'b0000);
        bus.load = 1'b0;
        run(8, P_LZ40, 4'b0000);
        run(16, P_LZ0, 4'b0000);

        // Frame 8: two loads in one frame, the second must win.
        run(2, P_LZ0, 4'b0000);
        drive(16'hFFFF, 1'b0, 4'b1111, 4'b1111);
        run(1, P_LZ0, 4'b0000);
        bus.load = 1'b0;
        run(6, P_LZ0, 4'b0000);
        drive(16'h0000, 1'b0, 4'b0010, 4'b0001);
        run(1, P_LZ0, 4'b0000);
        bus.load = 1'b0;
        run(6, P_LZ0, 4'b0000);

        // Frames 9-14: digit 1 blinks with a 2-frame half-period, dp on digit 0.
        run(16, P_ZERO, 4'b0001);
        run(32, P_BLNK, 4'b0001);
        run(32, P_ZERO, 4'b0001);

        // Frame 14: load on the exact boundary cycle; frame 15 shows 5678.
        run(15, P_BLNK, 4'b0001);
        drive(16'h5678, 1'b0, 4'b0000, 4'b0000);
        run(1, P_BLNK, 4'b0001);
        bus.load = 1'b0;
        run(16, P_5678, 4'b0000);

        // Frame 16: asynchronous reset mid-dwell, then restart from digit 0.
        run(6, P_5678, 4'b0000);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        run(16, P_ZERO, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hex_display_scan.md
# hex_display_scan

Parametrised multiplexed seven-segment display driver: DIGITS hex nibbles are decoded to segment patterns and scanned one digit at a time over shared segment lines with per-digit anode enables. It adds several behaviours to plain per-digit hex decoding:
- tear-free frame-synchronous value update
- leading-zero blanking
- per-digit blink and decimal point
- an anti-ghosting guard cycle

It sits between the datapath registers and the board's common-anode display pins.

## Interface
Parameters:
- DIGITS, 4, number of multiplexed digits (1..8); digit 0 is least significant.
- SCAN_DIV, 50000, clock cycles each digit is selected (dwell); must be ≥ 2.
- BLINK_FRAMES, 64, full scan frames per blink half-period; must be ≥ 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- value  in  4*DIGITS  hex nibbles; nibble i = value[4i+3:4i] drives digit i.
- load  in  1  one-cycle strobe; captures value, blank_lz, blink_mask and dp_mask into the pending register.
- blank_lz  in  1  leading-zero blanking enable.
- blink_mask  in  DIGITS  bit i = 1 makes digit i blink.
- dp_mask  in  DIGITS  bit i = 1 lights decimal point of digit i.
- seg  out  7  segments {g,f,e,d,c,b,a}, active low.
- an  out  DIGITS  anode enables, active low, at most one low.
- dp  out  1  decimal point, active low.
- frame_start  out  1  one-cycle pulse at the first cycle of digit 0's dwell.

## Operation
- **Prescaler.** `div_cnt` counts 0..SCAN_DIV-1. At SCAN_DIV-1 it wraps and the digit index advances.
- **Digit index.** `idx` counts 0..DIGITS-1 and wraps to 0.
- **Frame boundary.** The cycle where `div_cnt` = SCAN_DIV-1 and `idx` = DIGITS-1.
- **Registers.** Two register sets: pending and shadow.
  - load writes the pending set.
  - At each frame boundary, pending is copied to shadow. The display always uses shadow, so no frame mixes old and new values.
  - If load coincides with the frame boundary, the loaded inputs go directly into both pending and shadow.
- **Blink.** `blink_cnt` counts frames 0..BLINK_FRAMES-1. On wrap it toggles `blink_on`.
  - When `blink_on` = 0, digits with their shadow blink_mask bit set are blanked.
  - Their dp is blanked too.
- **Leading-zero blanking.** When shadow blank_lz = 1, digit i (i > 0) is blanked if nibbles i..DIGITS-1 are all zero. Digit 0 is never blanked by this rule.
- **Decode.** Active-low, {g..a} bit order:
  - 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001, 5:0010010, 6:0000010, 7:1111000
  - 8:0000000, 9:0011000, A:0001000, b:0000011, C:1000110, d:0100001, E:0000110, F:0001110
- **Blanked digit.** seg = 1111111; its anode is still driven.
- **Guard.** In the first cycle of every dwell (`div_cnt` = 0), `an` is all ones. This prevents ghosting while seg changes.

## Timing
- All outputs are registered. Output values reflect `div_cnt`/`idx` from the previous cycle (1-cycle pipeline).
- Reset values:
  - seg = 7'h7F, an = all ones, dp = 1, frame_start = 0.
  - `div_cnt` = 0, `idx` = 0, `blink_cnt` = 0, `blink_on` = 1.
  - pending and shadow all zero, i.e. display "0" with leading zeros unblanked.
- Frame length = DIGITS·SCAN_DIV cycles. Digit i's anode is low for SCAN_DIV-1 cycles per frame.
- frame_start is high exactly once per frame, on the output cycle where `an` is all ones for digit 0's guard.
- A load takes effect at the next frame boundary. Worst-case latency is DIGITS·SCAN_DIV cycles plus 1 pipeline cycle.
- Back-to-back loads within one frame: the last one wins.
- Reset asserted mid-frame returns all state to reset values immediately. Scanning restarts at digit 0 on the first clock after release.

## Structure
- Shared package `display_pkg`: 16-entry segment code constants, SEG_BLANK = 7'h7F, active-low polarity constants.
- Sub-module `hex_seg_lut`: combinational 4-bit → 7-bit decode. Instantiated once on the muxed nibble.
- Top holds the prescaler, index, blink counter, pending/shadow registers, blanking logic and output registers.

## Test plan
All scenarios use DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2.
1. **Reset/scan.** Reset, then idle. Outputs:
   - an sequence per dwell: 1111,1110,1110,1110, then 1111,1101,..., through digit 3, then wrap.
   - seg = 1000000 on every lit cycle.
   - frame_start every 16 cycles.
2. **Load/tear-free.** load value=16'hA3F0 mid-frame. The current frame still shows 0000; the next frame shows digit0 = 1000000, digit1 = 0001110, digit2 = 0110000, digit3 = 0001000.
3. **Leading-zero blanking.** load value=16'h0040, blank_lz=1. Digits 3 and 2 show seg = 1111111; digit1 = 0011001; digit0 = 1000000. With value=0, only digit 0 is lit.
4. **Blink/dp.** load blink_mask=4'b0010, dp_mask=4'b0001. Digit 1 alternates visible/blank every 2 frames. dp = 0 only during digit 0's lit cycles.
5. **Boundary load + reset.** Assert load on the exact frame-boundary cycle; the new value appears in the immediately following frame. Then pulse rst_n low mid-dwell: outputs return to reset values asynchronously.
